// File: rtl/hazard_stall_controller.sv
// Hazard and sequencing controller for a 5-stage MIPS pipeline.
// Decides, each cycle, whether the front end must stall, flush or hold for
// a multi-cycle multiply/divide, and keeps saturating stall/flush counters.
module hazard_stall_controller #(
    parameter int MULT_LATENCY = 4
) (
    input  logic        Clk_in,
    input  logic        Reset_in,
    input  logic [4:0]  rs_ID,
    input  logic [4:0]  rt_ID,
    input  logic        UsesRs_ID,
    input  logic        UsesRt_ID,
    input  logic        Jump_ID,
    input  logic        JR_ID,
    input  logic        MemRead_EX,
    input  logic [4:0]  rt_EX,
    input  logic        MultStart_EX,
    input  logic        BranchTaken_EX,
    output logic        PCWrite_out,
    output logic        IF_ID_Write_out,
    output logic        IF_ID_Flush_out,
    output logic        ID_EX_Write_out,
    output logic        ID_EX_Bubble_out,
    output logic        EX_MEM_Bubble_out,
    output logic        Busy_out,
    output logic [15:0] StallCycles_out,
    output logic [15:0] FlushCount_out
);

    // The start cycle is the first stall cycle, so the wait counter only
    // covers the remaining MULT_LATENCY-1 cycles.
    localparam logic [7:0] WAIT_LOAD = 8'(MULT_LATENCY - 1);

    typedef enum logic {
        RUN,
        MULT_WAIT
    } state_t;

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;

    logic load_use;
    logic sel_wait;
    logic sel_branch;
    logic sel_mult_start;
    logic sel_load_use;
    logic sel_jump;
    logic stall_event;
    logic flush_event;

    // Performance counters stick at all-ones rather than wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end
        return value + 16'd1;
    endfunction

    // A load writing $zero can never create a true dependence.
    assign load_use = MemRead_EX && (rt_EX != 5'd0) &&
                      ((UsesRs_ID && (rs_ID == rt_EX)) ||
                       (UsesRt_ID && (rt_ID == rt_EX)));

    // Priority decode: exactly one case (or none) is selected each cycle.
    always_comb begin
        sel_wait       = 1'b0;
        sel_branch     = 1'b0;
        sel_mult_start = 1'b0;
        sel_load_use   = 1'b0;
        sel_jump       = 1'b0;
        if (!Reset_in) begin
            if (state == MULT_WAIT) begin
                sel_wait = 1'b1;
            end else if (BranchTaken_EX) begin
                // The ID instruction is wrong-path, so its hazards are moot.
                sel_branch = 1'b1;
            end else if (MultStart_EX) begin
                sel_mult_start = 1'b1;
            end else if (load_use) begin
                // A dependent JR stalls here and flushes on the next cycle.
                sel_load_use = 1'b1;
            end else if (Jump_ID || JR_ID) begin
                sel_jump = 1'b1;
            end
        end
    end

    assign stall_event = sel_wait || sel_mult_start || sel_load_use;
    assign flush_event = sel_branch || sel_jump;

    // Pipeline-register controls, combinational so they act in the same cycle.
    always_comb begin
        PCWrite_out       = 1'b1;
        IF_ID_Write_out   = 1'b1;
        IF_ID_Flush_out   = 1'b0;
        ID_EX_Write_out   = 1'b1;
        ID_EX_Bubble_out  = 1'b0;
        EX_MEM_Bubble_out = 1'b0;
        Busy_out          = 1'b0;
        if (sel_wait || sel_mult_start) begin
            // Freeze IF/ID/EX and drain bubbles behind the held multiply.
            PCWrite_out       = 1'b0;
            IF_ID_Write_out   = 1'b0;
            ID_EX_Write_out   = 1'b0;
            EX_MEM_Bubble_out = 1'b1;
            Busy_out          = sel_wait;
        end else if (sel_branch) begin
            // PC keeps writing: it loads the branch target this cycle.
            IF_ID_Flush_out  = 1'b1;
            ID_EX_Bubble_out = 1'b1;
        end else if (sel_load_use) begin
            PCWrite_out      = 1'b0;
            IF_ID_Write_out  = 1'b0;
            ID_EX_Bubble_out = 1'b1;
        end else if (sel_jump) begin
            IF_ID_Flush_out = 1'b1;
        end
    end

    assign StallCycles_out = stall_cycles;
    assign FlushCount_out  = flush_count;

    // Sequencing state, wait counter and performance counters.
    always_ff @(posedge Clk_in) begin
        if (Reset_in) begin
            state        <= RUN;
            wait_cnt     <= 8'd0;
            stall_cycles <= 16'd0;
            flush_count  <= 16'd0;
        end else begin
            if (stall_event) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
            if (flush_event) begin
                flush_count <= sat_inc(flush_count);
            end
            if (sel_mult_start) begin
                wait_cnt <= WAIT_LOAD;
                state    <= MULT_WAIT;
            end else if (sel_wait) begin
                // Release on the last count; <=1 also guards a stray zero.
                if (wait_cnt <= 8'd1) begin
                    state    <= RUN;
                    wait_cnt <= 8'd0;
                end else begin
                    wait_cnt <= wait_cnt - 8'd1;
                end
            end
        end
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Pipeline hazard and sequencing controller for the 5-stage MIPS datapath. It watches the instruction in ID and the instructions in EX. It drives the PC, IF/ID, ID/EX and EX/MEM write, flush and bubble controls for four cases: load-use stalls, taken-branch flushes, jump/JR flushes, and holding a multi-cycle multiply/divide in EX. It also keeps saturating stall and flush counters for performance measurement.

Parameters:
MULT_LATENCY, 4, total EX occupancy in cycles of a multi-cycle op; legal range 2..255.

Ports:
Clk_in  input  1  clock; all state updates on the rising edge.
Reset_in  input  1  synchronous, active-high reset.
rs_ID  input  5  rs field of the instruction in ID.
rt_ID  input  5  rt field of the instruction in ID.
UsesRs_ID  input  1  ID instruction reads rs.
UsesRt_ID  input  1  ID instruction reads rt.
Jump_ID  input  1  ID instruction is J or JAL.
JR_ID  input  1  ID instruction is JR.
MemRead_EX  input  1  EX instruction is a load.
rt_EX  input  5  destination register of the load in EX.
MultStart_EX  input  1  EX instruction is a multi-cycle multiply/divide.
BranchTaken_EX  input  1  branch in EX resolved as taken.
PCWrite_out  output  1  PC update enable.
IF_ID_Write_out  output  1  IF/ID register write enable.
IF_ID_Flush_out  output  1  zero the IF/ID register (NOP).
ID_EX_Write_out  output  1  ID/EX register write enable.
ID_EX_Bubble_out  output  1  load zeroed control signals into ID/EX.
EX_MEM_Bubble_out  output  1  load zeroed control signals into EX/MEM.
Busy_out  output  1  high while in MULT_WAIT.
StallCycles_out  output  16  count of stall cycles, saturating.
FlushCount_out  output  16  count of flush events, saturating.

Behaviour:
- States: RUN and MULT_WAIT. Registered elements are the state, an 8-bit wait counter, and the two performance counters.
- Control outputs are combinational from state and inputs; there is zero-cycle latency to the pipeline registers.
- Default values (no hazard case active): PCWrite=1, IF_ID_Write=1, ID_EX_Write=1; all flush and bubble outputs 0.
- load_use = MemRead_EX & (rt_EX!=0) & ((UsesRs_ID & rs_ID==rt_EX) | (UsesRt_ID & rt_ID==rt_EX)).
- Priority, highest first. Only the highest active case applies; all other outputs keep their defaults.
  1. Reset_in=1: outputs forced to defaults. Next state RUN, counter 0, StallCycles=0, FlushCount=0. Applies mid-MULT_WAIT.
  2. MULT_WAIT: PCWrite=0, IF_ID_Write=0, ID_EX_Write=0, EX_MEM_Bubble=1, Busy=1. All other inputs are ignored. StallCycles increments. If counter==1, next state is RUN; otherwise counter decrements.
  3. RUN & BranchTaken_EX: IF_ID_Flush=1, ID_EX_Bubble=1; PC loads the branch target. FlushCount increments by 1.
  4. RUN & MultStart_EX: same stall outputs as MULT_WAIT (Busy=0 this cycle). StallCycles increments. Counter loads MULT_LATENCY-1 and next state is MULT_WAIT. Total stall is exactly MULT_LATENCY cycles.
  5. RUN & load_use: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1. StallCycles increments. No state change; the hazard clears next cycle.
  6. RUN & (Jump_ID | JR_ID): IF_ID_Flush=1. FlushCount increments.
- Boundary cases:
  - A taken branch overrides load_use and jump in ID, because the ID instruction is wrong-path.
  - A JR whose rs depends on a load in EX stalls first. The flush fires on the following cycle.
  - A jump held in ID during MULT_WAIT is flushed only after release.
  - Both counters saturate at 0xFFFF and do not wrap.
  - rt_EX=0 never causes a stall.
- Reset values of outputs: PCWrite=1, IF_ID_Write=1, ID_EX_Write=1, IF_ID_Flush=0, ID_EX_Bubble=0, EX_MEM_Bubble=0, Busy=0, StallCycles=0, FlushCount=0.

Test Plan:
1. Load-use: MemRead_EX=1, rt_EX=8, rs_ID=8, UsesRs_ID=1 for one cycle.
   -> PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1 that cycle; defaults next cycle; StallCycles=1.
2. rt_EX=0 with rs_ID=0, MemRead_EX=1.
   -> No stall; all outputs at defaults.
3. MultStart_EX=1 pulse with MULT_LATENCY=4.
   -> Stall outputs for exactly 4 cycles; Busy=1 on cycles 2-4; RUN on cycle 5; StallCycles=4.
4. BranchTaken_EX=1 with load_use and Jump_ID also true.
   -> IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1; FlushCount=1; StallCycles unchanged.
5. Reset_in=1 on the 2nd cycle of MULT_WAIT.
   -> Next cycle RUN, Busy=0, all counters 0, outputs at defaults.
6. Preload FlushCount to 0xFFFE, then 3 consecutive Jump_ID cycles.
   -> FlushCount=0xFFFF and holds; IF_ID_Flush=1 each cycle.
